// File: rtl/isr_host.sv
// Sequencer for one iterative square-root unit: operand FIFO, load/guard/run control, one-entry
// result register. Optional RUN watchdog enabled by defining ISR_HOST_TIMEOUT_EN.
module isr_host #(
   parameter int unsigned DEPTH       = 4,
   parameter int unsigned LOAD_CYCLES = 2,
   parameter int unsigned TIMEOUT     = 2048
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [63:0] in_value,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_root,
   output logic        out_err,
   output logic        busy,
   output logic        isr_reset,
   output logic [63:0] isr_value,
   input  logic [31:0] isr_result,
   input  logic        isr_done
);

   localparam int unsigned PtrW = $clog2(DEPTH);
   localparam int unsigned LcW  = $clog2(LOAD_CYCLES + 1);

   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || LOAD_CYCLES < 1 || TIMEOUT < 1) begin : g_bad
      $error("isr_host: illegal parameter combination");
   end

   typedef enum logic [2:0] {StIdle, StLoad, StGuard, StRun, StWaitOut} state_e;

   state_e             state_q, state_d;
   logic [PtrW:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [63:0]        mem_q [DEPTH];
   logic [63:0]        mem_d [DEPTH];
   logic [63:0]        isr_value_q, isr_value_d;
   logic [LcW-1:0]     load_cnt_q, load_cnt_d;
   logic               out_valid_q, out_valid_d;
   logic [31:0]        out_root_q, out_root_d;
   logic               out_err_q, out_err_d;
   logic               empty, full, push, out_free, aborted;
   logic               capture, cap_err;
   logic [31:0]        cap_root;

`ifdef ISR_HOST_TIMEOUT_EN
   localparam int unsigned TmoW = $clog2(TIMEOUT + 1);
   logic [TmoW-1:0]    tmo_q, tmo_d;
   logic               abort_q, abort_d;
   assign aborted = abort_q;
`else
   assign aborted = 1'b0;
`endif

   assign empty     = (wr_ptr_q == rd_ptr_q);
   assign full      = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                      (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);
   assign in_ready  = reset_n & ~full;
   assign push      = in_valid & in_ready;
   // The result register can take a new root if it is empty or drains this same cycle.
   assign out_free  = ~out_valid_q | out_ready;

   assign out_valid = out_valid_q;
   assign out_root  = out_root_q;
   assign out_err   = out_err_q;
   assign isr_value = isr_value_q;
   assign isr_reset = ~(state_q inside {StGuard, StRun, StWaitOut});
   assign busy      = (state_q != StIdle) | ~empty | out_valid_q;

   always_comb begin
      state_d     = state_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      mem_d       = mem_q;
      isr_value_d = isr_value_q;
      load_cnt_d  = load_cnt_q;
      out_valid_d = out_valid_q;
      out_root_d  = out_root_q;
      out_err_d   = out_err_q;
      capture     = 1'b0;
      cap_root    = isr_result;
      cap_err     = 1'b0;
`ifdef ISR_HOST_TIMEOUT_EN
      tmo_d       = tmo_q;
      abort_d     = abort_q;
`endif

      if (out_valid_q && out_ready) out_valid_d = 1'b0;

      if (push) begin
         mem_d[wr_ptr_q[PtrW-1:0]] = in_value;
         wr_ptr_d                  = wr_ptr_q + 1'b1;
      end

      unique case (state_q)
         StIdle: begin
            if (!empty) begin
               isr_value_d = mem_q[rd_ptr_q[PtrW-1:0]];
               rd_ptr_d    = rd_ptr_q + 1'b1;
               load_cnt_d  = LcW'(LOAD_CYCLES - 1);
               state_d     = StLoad;
            end
         end
         StLoad: begin
            if (load_cnt_q == '0) state_d = StGuard;
            else                  load_cnt_d = load_cnt_q - 1'b1;
         end
         StGuard: begin
            // isr_done is ignored here: the unit may still show done from the previous op.
`ifdef ISR_HOST_TIMEOUT_EN
            tmo_d   = '0;
            abort_d = 1'b0;
`endif
            state_d = StRun;
         end
         StRun: begin
            if (isr_done) begin
               if (out_free) begin
                  capture = 1'b1;
                  state_d = StIdle;
               end else begin
                  state_d = StWaitOut;
               end
`ifdef ISR_HOST_TIMEOUT_EN
            end else if (tmo_q == TmoW'(TIMEOUT - 1)) begin
               abort_d  = 1'b1;
               cap_root = '0;
               cap_err  = 1'b1;
               if (out_free) begin
                  capture = 1'b1;
                  state_d = StIdle;
               end else begin
                  state_d = StWaitOut;
               end
            end else begin
               tmo_d = tmo_q + 1'b1;
`endif
            end
         end
         StWaitOut: begin
            cap_root = aborted ? '0 : isr_result;
            cap_err  = aborted;
            if (out_free) begin
               capture = 1'b1;
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase

      if (capture) begin
         out_valid_d = 1'b1;
         out_root_d  = cap_root;
         out_err_d   = cap_err;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= StIdle;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         mem_q       <= '{default: '0};
         isr_value_q <= '0;
         load_cnt_q  <= '0;
         out_valid_q <= 1'b0;
         out_root_q  <= '0;
         out_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         mem_q       <= mem_d;
         isr_value_q <= isr_value_d;
         load_cnt_q  <= load_cnt_d;
         out_valid_q <= out_valid_d;
         out_root_q  <= out_root_d;
         out_err_q   <= out_err_d;
      end
   end

`ifdef ISR_HOST_TIMEOUT_EN
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         tmo_q   <= '0;
         abort_q <= 1'b0;
      end else begin
         tmo_q   <= tmo_d;
         abort_q <= abort_d;
      end
   end
`endif

endmodule
